// File: rtl/r200_pkg.sv
// r200 pipeline control: shared forwarding codes
// and per-stage hazard records.
package r200_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       isload;
    logic [4:0] rd;
  } rec_t;

  typedef struct packed {
    rec_t       r;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_rec_t;

endpackage

// File: rtl/r200_hazcmp.sv
// r200 hazard comparator: a live writer of rd
// matches source rs, never for x0.
module r200_hazcmp (
  input  logic       valid,
  input  logic       wen,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  output logic       match
);

  assign match = valid & wen
               & (rd != 5'd0)
               & (rd == rs);

endmodule

// File: rtl/r200_pipectl.sv
// r200 pipeline control: stalls, flushes,
// load-use bubbles and EX operand forwarding.
module r200_pipectl
  import r200_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_wen,
  input  logic             id_isload,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_isbranch,
  input  logic             ex_jump,
  input  logic             ex_willbr,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  ex_rec_t          ex_q;
  rec_t             mem_q;
  rec_t             wb_q;
  logic             live_q;
  logic [CNT_W-1:0] cnt_q;

  logic m1, m2, w1, w2, l1, l2;
  logic redirect, loaduse, lu_bubble;
  logic unused;

  r200_hazcmp u_m1 (
    .valid (mem_q.valid & ~mem_q.isload),
    .wen   (mem_q.wen),
    .rd    (mem_q.rd),
    .rs    (ex_q.rs1),
    .match (m1)
  );

  r200_hazcmp u_m2 (
    .valid (mem_q.valid & ~mem_q.isload),
    .wen   (mem_q.wen),
    .rd    (mem_q.rd),
    .rs    (ex_q.rs2),
    .match (m2)
  );

  r200_hazcmp u_w1 (
    .valid (wb_q.valid),
    .wen   (wb_q.wen),
    .rd    (wb_q.rd),
    .rs    (ex_q.rs1),
    .match (w1)
  );

  r200_hazcmp u_w2 (
    .valid (wb_q.valid),
    .wen   (wb_q.wen),
    .rd    (wb_q.rd),
    .rs    (ex_q.rs2),
    .match (w2)
  );

  r200_hazcmp u_l1 (
    .valid (ex_q.r.valid & ex_q.r.isload),
    .wen   (ex_q.r.wen),
    .rd    (ex_q.r.rd),
    .rs    (id_rs1),
    .match (l1)
  );

  r200_hazcmp u_l2 (
    .valid (ex_q.r.valid & ex_q.r.isload),
    .wen   (ex_q.r.wen),
    .rd    (ex_q.r.rd),
    .rs    (id_rs2),
    .match (l2)
  );

  assign redirect = ex_q.r.valid
                  & ((ex_isbranch & ex_willbr)
                     | ex_jump);

  assign loaduse = id_valid
                 & ((id_use_rs1 & l1)
                    | (id_use_rs2 & l2));

  assign fwd1_sel = m1 ? FWD_MEM
                  : w1 ? FWD_WB : FWD_REG;
  assign fwd2_sel = m2 ? FWD_MEM
                  : w2 ? FWD_WB : FWD_REG;

  assign bubble_cnt = cnt_q;
  assign unused     = wb_q.isload;

  // live_q masks control for the first cycle out of reset
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_redirect = 1'b0;
    lu_bubble   = 1'b0;
    if (live_q) begin
      if (mem_busy) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end else if (redirect) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (loaduse) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        lu_bubble   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      live_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      live_q <= 1'b1;
      if (lu_bubble && !(&cnt_q))
        cnt_q <= cnt_q + CNT_ONE;
      if (!mem_busy) begin
        wb_q           <= mem_q;
        mem_q          <= ex_q.r;
        ex_q.r.valid   <= id_valid & ~idex_bubble;
        ex_q.r.wen     <= id_wen;
        ex_q.r.isload  <= id_isload;
        ex_q.r.rd      <= id_rd;
        ex_q.rs1       <= id_rs1;
        ex_q.rs2       <= id_rs2;
      end
    end
  end

endmodule

// File: doc/r200_pipectl.md
R200_PIPECTL -- requirements
Module: r200_pipectl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports id_valid, id_wen, id_isload, id_use_rs1, id_use_rs2  in  1 each  ID-stage instruction attributes.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rd  in  5 each  ID-stage register indices.
REQ-006 SHALL have ports ex_isbranch, ex_jump  in  1 each  EX instruction is a conditional branch or a jal/jalr.
REQ-007 SHALL have port ex_willbr  in  1  branch-taken flag from the execute stage.
REQ-008 SHALL have port mem_busy  in  1  data memory not ready; freezes the pipeline.
REQ-009 SHALL have ports pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_redirect  out  1 each  pipeline control.
REQ-010 SHALL have ports fwd1_sel, fwd2_sel  out  2 each  EX operand source for op1/op2.
REQ-011 SHALL have port bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-012 SHALL keep per-stage records for EX, MEM and WB: valid, rd, wen, isload; EX additionally holds rs1, rs2.
REQ-013 SHALL advance records when mem_busy=0: WB<=MEM, MEM<=EX, EX<=ID fields with valid=id_valid & ~idex_bubble.
REQ-014 SHALL hold all records unchanged while mem_busy=1.
REQ-015 SHALL define redirect = EX.valid & ((ex_isbranch & ex_willbr) | ex_jump).
REQ-016 SHALL define loaduse = EX.valid & EX.isload & EX.wen & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
REQ-017 SHALL, when mem_busy=1, assert pc_stall=ifid_stall=1 and deassert pc_redirect, ifid_flush, idex_bubble.
REQ-018 SHALL, when mem_busy=0 and redirect, assert pc_redirect, ifid_flush and idex_bubble, and deassert pc_stall and ifid_stall (redirect beats loaduse).
REQ-019 SHALL, when mem_busy=0, ~redirect and loaduse, assert pc_stall, ifid_stall and idex_bubble.
REQ-020 SHALL drive all control outputs 0 when none of REQ-017..019 apply.
REQ-021 SHALL select fwdN_sel: 2'b01 (MEM) if MEM.valid & MEM.wen & ~MEM.isload & MEM.rd!=0 & MEM.rd==EX.rsN; else 2'b10 (WB) if WB.valid & WB.wen & WB.rd!=0 & WB.rd==EX.rsN; else 2'b00 (register file).
REQ-022 SHALL never stall or forward on rd=x0.
REQ-023 SHALL derive all outputs combinationally from the current records and ID inputs; no added latency.
REQ-024 SHALL increment bubble_cnt by 1 in each cycle where REQ-019 applies, saturating at all-ones.

Reset
REQ-025 SHALL clear all record valid bits, rd/rs fields and bubble_cnt to 0 asynchronously on rst_n=0.
REQ-026 SHALL, while in reset and in the first cycle after it, drive every control output 0 and fwd1_sel=fwd2_sel=2'b00.
REQ-027 SHALL discard any in-flight stall or redirect on reset mid-operation; none resumes afterwards.

Structure
REQ-028 SHALL place FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10 and the stage-record typedef in shared package r200_pkg.
REQ-029 SHALL instantiate sub-module r200_hazcmp (valid, wen, rd, rs -> match, excluding x0) for every forwarding and load-use comparison.

Verification
REQ-030 SHALL cover: add x5 in EX, then consumer using x5 reaches EX one cycle later -> fwd1_sel=01 for one cycle.
REQ-031 SHALL cover: lw x7 in EX, ID uses rs2=x7 -> pc_stall/ifid_stall/idex_bubble=1 for exactly one cycle, then fwd2_sel=10, bubble_cnt=1.
REQ-032 SHALL cover: taken beq in EX (ex_willbr=1) while ID has load-use hazard -> pc_redirect=ifid_flush=idex_bubble=1, pc_stall=0, bubble_cnt unchanged.
REQ-033 SHALL cover: mem_busy=1 for 3 cycles during taken branch -> pc_redirect=0 for those cycles, records frozen, pc_redirect=1 on the first cycle with mem_busy=0.
REQ-034 SHALL cover: writes to x0 in MEM and WB with consumer reading x0 -> fwd sel=00, no stall.
REQ-035 SHALL cover: CNT_W=2, 5 load-use bubbles -> bubble_cnt saturates at 3; rst_n pulse mid-stall -> all outputs 0 immediately.
